// File: rtl/reg_file_mp_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared types and helpers for the multi-read-port register file.
//   clr_state_t   : clear-sequencer states (CLEAR sweeps the array, IDLE serves
//                   user writes)
//   BYTE_W        : width of one byte lane covered by a byte-enable bit
//   be_merge_byte : selects the new or the old byte for one byte lane; used by
//                   both the write path and the optional read bypass so the two
//                   can never disagree on what a write produces
// -----------------------------------------------------------------------------
package reg_file_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    localparam int BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] be_merge_byte(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              enable
    );
        return enable ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_clr_ctrl
// Clear sequencer: after reset, or on a clr_req seen while idle, walks every
// address once and asks the array to write zero there.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset (forces a fresh sweep)
//   clr_req   in   single-cycle request to start a sweep (ignored mid-sweep)
//   busy      out  high while the sweep runs
//   clr_we    out  write strobe for the zeroing write
//   clr_addr  out  address being zeroed this cycle
// -----------------------------------------------------------------------------
module reg_file_clr_ctrl
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_t            r_state;
    clr_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                // clr_req is deliberately not looked at here: a sweep is never
                // restarted or stretched by a second request.
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_next   = IDLE;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = CLEAR;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_clr_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// 2**ADDR_WIDTH x DATA_WIDTH register file with one byte-enabled synchronous
// write port, NUM_RD asynchronous read ports and a built-in clear sweep that
// zeroes the array after reset or on clr_req. The array itself has no reset;
// known contents come from the sweep.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   clr_req   in   request a clear sweep (honoured only when idle)
//   busy      out  sweep in progress; reads return 0, writes are dropped
//   wr_en     in   write request
//   wr_ready  out  write accepted when wr_en && wr_ready (== ~busy)
//   w_addr    in   write address
//   wr_be     in   byte enables, bit k covers data_in[8k+7:8k]
//   data_in   in   write data
//   r_addr    in   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_out  out  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
// Build option:
//   REG_FILE_MP_READ_BYPASS_EN - when defined, a read port addressing the word
//   being written this cycle returns the merged (post-write) word immediately.
// -----------------------------------------------------------------------------
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr_req,
    output logic                         busy,
    input  logic                         wr_en,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;

    generate
        if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_data_width
            $error("reg_file_mp: DATA_WIDTH must be a multiple of 8");
        end
        if (NUM_RD < 1) begin : g_bad_num_rd
            $error("reg_file_mp: NUM_RD must be at least 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_fire;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    reg_file_clr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign busy      = w_busy;
    assign wr_ready  = ~w_busy;
    assign w_wr_fire = wr_en & ~w_busy;
    assign w_wr_old  = r_mem[w_addr];

    // Word as it will look after the write; feeds the array and the bypass.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
            assign w_merged[gi*BYTE_W +: BYTE_W] =
                be_merge_byte(w_wr_old[gi*BYTE_W +: BYTE_W],
                              data_in[gi*BYTE_W +: BYTE_W],
                              wr_be[gi]);
        end
    endgenerate

    // The sweep owns the port while busy; user writes only happen when idle,
    // so the two never compete in the same cycle.
    assign w_mem_we    = w_clr_we | (w_wr_fire & (|wr_be));
    assign w_mem_addr  = w_clr_we ? w_clr_addr : w_addr;
    assign w_mem_wdata = w_clr_we ? '0 : w_merged;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_rd_addr;
            logic [DATA_WIDTH-1:0] w_rd_word;

            assign w_rd_addr = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                w_rd_word = r_mem[w_rd_addr];
`ifdef REG_FILE_MP_READ_BYPASS_EN
                if (w_wr_fire && (w_rd_addr == w_addr)) begin
                    w_rd_word = w_merged;
                end
`endif
            end

            // Zero forcing wins over the bypass: nothing is visible mid-sweep.
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = w_busy ? '0 : w_rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 16;
    localparam int BW    = DW / 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           clr_req;
    logic           busy;
    logic           wr_en;
    logic           wr_ready;
    logic [AW-1:0]  w_addr;
    logic [BW-1:0]  wr_be;
    logic [DW-1:0]  data_in;
    logic [NR*AW-1:0] r_addr;
    logic [NR*DW-1:0] data_out;

    reg_file_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RD     (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .w_addr   (w_addr),
        .wr_be    (wr_be),
        .data_in  (data_in),
        .r_addr   (r_addr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain word array plus "edges of sweep still to go".
    logic [DW-1:0] mem_m [DEPTH];
    int            sweep_left;

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [BW-1:0] be);
        logic [DW-1:0] res;
        res = old_w;
        for (int k = 0; k < BW; k++)
            if (be[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
        return res;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%08h expected=%08h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [AW-1:0] a;
        logic [DW-1:0] exp;
        check_bit("busy", busy, sweep_left > 0);
        check_bit("wr_ready", wr_ready, !(sweep_left > 0));
        for (int i = 0; i < NR; i++) begin
            a = r_addr[i*AW +: AW];
            if (sweep_left > 0) begin
                exp = '0;
            end else begin
                exp = mem_m[a];
`ifdef REG_FILE_MP_READ_BYPASS_EN
                if (wr_en && a == w_addr) exp = merge_m(exp, data_in, wr_be);
`endif
            end
            check_word($sformatf("dout%0d_a%0d", i, a), data_out[i*DW +: DW], exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            mem_m[DEPTH - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (wr_en) mem_m[w_addr] = merge_m(mem_m[w_addr], data_in, wr_be);
            if (clr_req) sweep_left = DEPTH;
        end
    endtask

    // Caller drives inputs at the falling edge; outputs are checked 1 time unit
    // later, the model advances on the rising edge, and we return at the next
    // falling edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                          input logic [DW-1:0] d, input logic clr,
                          input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wr_en   = we;
        w_addr  = wa;
        wr_be   = be;
        data_in = d;
        clr_req = clr;
        r_addr  = {ra1, ra0};
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        sweep_left = DEPTH;
        reset = 1'b1;
        set_in(1'b0, '0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset held: busy, not ready, zero reads.
        step();
        step();
        reset = 1'b0;

        // Initial sweep: 16 busy cycles, each checked against the model.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, AW'(i), '1, $urandom, 1'b0, AW'(i), AW'(DEPTH - 1 - i));
            step();
        end
        // Every address reads zero afterwards.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b0, '0, '0, '0, 1'b0, AW'(i), AW'(DEPTH - 1 - i));
            step();
        end

        // Byte-enable merge.
        set_in(1'b1, 4'd3, 4'b1111, 32'hAABBCCDD, 1'b0, 4'd0, 4'd1);
        step();
        set_in(1'b1, 4'd3, 4'b0101, 32'h11223344, 1'b0, 4'd0, 4'd1);
        step();
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd3, 4'd3);
        #1 check_word("merge_const", data_out[DW-1:0], 32'hAA22CC44);
        step();

        // Shared address on two ports, then port1 moves to address 0.
        set_in(1'b1, 4'd5, 4'hF, 32'h12345678, 1'b0, 4'd0, 4'd0);
        step();
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd5, 4'd5);
        #1 check_word("shared_p1", data_out[2*DW-1:DW], 32'h12345678);
        step();
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd5, 4'd0);
        step();

        // Same-cycle read of the word being written.
        set_in(1'b1, 4'd7, 4'hF, 32'hDEADBEEF, 1'b0, 4'd7, 4'd7);
`ifdef REG_FILE_MP_READ_BYPASS_EN
        #1 check_word("rw_same", data_out[DW-1:0], 32'hDEADBEEF);
`else
        #1 check_word("rw_same", data_out[DW-1:0], 32'h00000000);
`endif
        step();
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd7, 4'd3);
        #1 check_word("rw_next", data_out[DW-1:0], 32'hDEADBEEF);
        step();

        // Clear request with a same-cycle write; writes held during the sweep.
        set_in(1'b1, 4'd2, 4'hF, 32'hCAFEF00D, 1'b0, 4'd2, 4'd9);
        step();
        set_in(1'b1, 4'd9, 4'hF, 32'h99999999, 1'b1, 4'd2, 4'd9);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 4'd2, 4'hF, 32'h55AA55AA, (i % 3) == 0, 4'd2, 4'd9);
            step();
        end
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd2, 4'd9);
        #1 check_word("clr_a2", data_out[DW-1:0], 32'h0);
        check_word("clr_a9", data_out[2*DW-1:DW], 32'h0);
        step();

        // Reset in the middle of a sweep restarts it from address 0.
        set_in(1'b1, 4'd4, 4'hF, 32'h44444444, 1'b0, 4'd4, 4'd4);
        step();
        set_in(1'b0, '0, '0, '0, 1'b1, 4'd4, 4'd0);
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1 check_bit("restart_busy", busy, 1'b1);
            step();
        end
        set_in(1'b0, '0, '0, '0, 1'b0, 4'd4, 4'd15);
        step();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 3) != 0, AW'($urandom), BW'($urandom), $urandom,
                   $urandom_range(0, 39) == 0, AW'($urandom), AW'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
